// File: rtl/cross_bar_pkg.sv
// cross_bar_pkg: shared cross bar sizes, id types and request packet layout
package cross_bar_pkg;
    localparam int NUM_CH   = 3;
    localparam int NUM_BANK = 4;
    localparam int ENTRY_W  = 3;
    localparam int REQ_W    = 64;
    typedef logic [1:0]         ch_id_t;
    typedef logic [ENTRY_W-1:0] entry_id_t;
    typedef struct packed {
        ch_id_t           ch;
        entry_id_t        entry;
        logic [REQ_W-1:0] data;
    } req_pkt_t;
endpackage

// File: rtl/cross_bar_rr_arb.sv
// cross_bar_rr_arb: combinational rotating-priority arbiter, search starts after the last winner
module cross_bar_rr_arb
    import cross_bar_pkg::*;
#(
    parameter int N = cross_bar_pkg::NUM_CH
) (
    input  logic [N-1:0] req_i,
    input  ch_id_t       last_i,
    output logic [N-1:0] gnt_o,
    output ch_id_t       id_o,
    output logic         any_o
);
    logic   found;
    ch_id_t idx;
    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = ch_id_t'((int'(last_i) + k) % N);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                id_o       = idx;
            end
        end
    end
    assign any_o = |req_i;
endmodule

// File: rtl/cross_bar_bank_port.sv
// cross_bar_bank_port: per-bank round-robin request issue with credit limit and response return path
module cross_bar_bank_port
    import cross_bar_pkg::*;
#(
    parameter int NUM_CH    = cross_bar_pkg::NUM_CH,
    parameter int ENTRY_W   = cross_bar_pkg::ENTRY_W,
    parameter int REQ_W     = 64,
    parameter int RESP_W    = 64,
    parameter int MAX_OUTST = 4
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic [NUM_CH-1:0]                ch_req_valid_i,
    input  logic [NUM_CH-1:0][ENTRY_W-1:0]   ch_req_entry_i,
    input  logic [NUM_CH-1:0][REQ_W-1:0]     ch_req_data_i,
    output logic [NUM_CH-1:0]                ch_req_grant_o,
    output logic                             bank_req_valid_o,
    input  logic                             bank_req_ready_i,
    output logic [1:0]                       bank_req_ch_o,
    output logic [ENTRY_W-1:0]               bank_req_entry_o,
    output logic [REQ_W-1:0]                 bank_req_data_o,
    input  logic                             bank_resp_valid_i,
    output logic                             bank_resp_ready_o,
    input  logic [1:0]                       bank_resp_ch_i,
    input  logic [RESP_W-1:0]                bank_resp_data_i,
    output logic [NUM_CH-1:0]                ch_resp_valid_o,
    input  logic [NUM_CH-1:0]                ch_resp_ready_i,
    output logic [RESP_W-1:0]                ch_resp_data_o
);
    localparam int            CW      = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTST);
    localparam ch_id_t        LAST_CH = ch_id_t'(NUM_CH - 1);

    logic               req_v_q, req_v_d;
    ch_id_t             req_ch_q, req_ch_d;
    logic [ENTRY_W-1:0] req_entry_q, req_entry_d;
    logic [REQ_W-1:0]   req_data_q, req_data_d;
    ch_id_t             last_q, last_d;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic               resp_v_q, resp_v_d;
    ch_id_t             resp_ch_q, resp_ch_d;
    logic [RESP_W-1:0]  resp_data_q, resp_data_d;
    logic [NUM_CH-1:0]  arb_gnt;
    ch_id_t             win_id;
    logic               any_req, bank_fire, can_load, resp_hs, resp_cap;

    cross_bar_rr_arb #(.N(NUM_CH)) u_arb (
        .req_i  (ch_req_valid_i),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .id_o   (win_id),
        .any_o  (any_req)
    );

    // grant is gated by reset so channels holding valid through reset see no capture
    assign bank_fire         = req_v_q & bank_req_ready_i;
    assign can_load          = rstn_i & (~req_v_q | bank_fire) & (inflight_q < MAX_C) & any_req;
    assign ch_req_grant_o    = can_load ? arb_gnt : '0;
    assign ch_resp_valid_o   = resp_v_q ? (NUM_CH'(1) << resp_ch_q) : '0;
    assign resp_hs           = |(ch_resp_valid_o & ch_resp_ready_i);
    assign bank_resp_ready_o = ~resp_v_q | resp_hs;
    assign resp_cap          = bank_resp_valid_i & bank_resp_ready_o;

    always_comb begin
        req_v_d     = can_load | (req_v_q & ~bank_fire);
        req_ch_d    = can_load ? win_id : req_ch_q;
        req_entry_d = can_load ? ch_req_entry_i[win_id] : req_entry_q;
        req_data_d  = can_load ? ch_req_data_i[win_id] : req_data_q;
        last_d      = can_load ? win_id : last_q;
        inflight_d  = (can_load && !resp_hs) ? inflight_q + CW'(1) :
                      (!can_load && resp_hs) ? inflight_q - CW'(1) : inflight_q;
        resp_v_d    = resp_cap | (resp_v_q & ~resp_hs);
        resp_ch_d   = resp_cap ? bank_resp_ch_i : resp_ch_q;
        resp_data_d = resp_cap ? bank_resp_data_i : resp_data_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            req_v_q     <= 1'b0;
            req_ch_q    <= '0;
            req_entry_q <= '0;
            req_data_q  <= '0;
            last_q      <= LAST_CH;
            inflight_q  <= '0;
            resp_v_q    <= 1'b0;
            resp_ch_q   <= '0;
            resp_data_q <= '0;
        end else begin
            req_v_q     <= req_v_d;
            req_ch_q    <= req_ch_d;
            req_entry_q <= req_entry_d;
            req_data_q  <= req_data_d;
            last_q      <= last_d;
            inflight_q  <= inflight_d;
            resp_v_q    <= resp_v_d;
            resp_ch_q   <= resp_ch_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign bank_req_valid_o = req_v_q;
    assign bank_req_ch_o    = req_ch_q;
    assign bank_req_entry_o = req_entry_q;
    assign bank_req_data_o  = req_data_q;
    assign ch_resp_data_o   = resp_data_q;

    a_resp_ch: assert property (@(posedge clk_i) disable iff (!rstn_i)
        bank_resp_valid_i |-> bank_resp_ch_i <= LAST_CH);
    a_resp_credit: assert property (@(posedge clk_i) disable iff (!rstn_i)
        bank_resp_valid_i |-> inflight_q != '0);
    a_req_hold: assert property (@(posedge clk_i) disable iff (!rstn_i)
        req_v_q && !bank_req_ready_i |=> req_v_q);
endmodule

// File: tb/tb_cross_bar_bank_port.sv
// tb_cross_bar_bank_port: directed stimulus with queue scoreboard for grants, bank requests and responses
module tb_cross_bar_bank_port;
    import cross_bar_pkg::*;

    typedef struct packed {
        logic [2:0]  vld;
        logic [63:0] data;
    } resp_exp_t;

    logic             clk_i = 1'b0;
    logic             rstn_i;
    logic [2:0]       ch_req_valid_i;
    logic [2:0][2:0]  ch_req_entry_i;
    logic [2:0][63:0] ch_req_data_i;
    logic [2:0]       ch_req_grant_o;
    logic             bank_req_valid_o;
    logic             bank_req_ready_i;
    logic [1:0]       bank_req_ch_o;
    logic [2:0]       bank_req_entry_o;
    logic [63:0]      bank_req_data_o;
    logic             bank_resp_valid_i;
    logic             bank_resp_ready_o;
    logic [1:0]       bank_resp_ch_i;
    logic [63:0]      bank_resp_data_i;
    logic [2:0]       ch_resp_valid_o;
    logic [2:0]       ch_resp_ready_i;
    logic [63:0]      ch_resp_data_o;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_gnt[$];
    req_pkt_t   exp_req[$];
    resp_exp_t  exp_resp[$];

    cross_bar_bank_port dut (
        .clk_i             (clk_i),
        .rstn_i            (rstn_i),
        .ch_req_valid_i    (ch_req_valid_i),
        .ch_req_entry_i    (ch_req_entry_i),
        .ch_req_data_i     (ch_req_data_i),
        .ch_req_grant_o    (ch_req_grant_o),
        .bank_req_valid_o  (bank_req_valid_o),
        .bank_req_ready_i  (bank_req_ready_i),
        .bank_req_ch_o     (bank_req_ch_o),
        .bank_req_entry_o  (bank_req_entry_o),
        .bank_req_data_o   (bank_req_data_o),
        .bank_resp_valid_i (bank_resp_valid_i),
        .bank_resp_ready_o (bank_resp_ready_o),
        .bank_resp_ch_i    (bank_resp_ch_i),
        .bank_resp_data_i  (bank_resp_data_i),
        .ch_resp_valid_o   (ch_resp_valid_o),
        .ch_resp_ready_i   (ch_resp_ready_i),
        .ch_resp_data_o    (ch_resp_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic neg();
        @(negedge clk_i);
    endtask

    task automatic push_req(input logic [1:0] w);
        exp_gnt.push_back(3'b001 << w);
        exp_req.push_back({w, ch_req_entry_i[w], ch_req_data_i[w]});
    endtask

    task automatic send_resp(input logic [1:0] c, input logic [63:0] d);
        bank_resp_valid_i = 1'b1;
        bank_resp_ch_i    = c;
        bank_resp_data_i  = d;
        exp_resp.push_back({3'b001 << c, d});
    endtask

    always @(negedge clk_i) begin
        if (rstn_i && ch_req_grant_o != 3'b000) begin
            if (exp_gnt.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL grant: unexpected grant %b", ch_req_grant_o);
            end else chk("grant", 128'(ch_req_grant_o), 128'(exp_gnt.pop_front()));
        end
    end

    always @(negedge clk_i) begin
        if (rstn_i && bank_req_valid_o && bank_req_ready_i) begin
            if (exp_req.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_fire: unexpected request ch=%0d entry=%0d", bank_req_ch_o, bank_req_entry_o);
            end else chk("req_fire", 128'({bank_req_ch_o, bank_req_entry_o, bank_req_data_o}), 128'(exp_req.pop_front()));
        end
    end

    always @(negedge clk_i) begin
        if (rstn_i && |(ch_resp_valid_o & ch_resp_ready_i)) begin
            if (exp_resp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp: unexpected response valid=%b", ch_resp_valid_o);
            end else chk("resp", 128'({ch_resp_valid_o, ch_resp_data_o}), 128'(exp_resp.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rstn_i = 1'b0;
        ch_req_valid_i = '0;
        ch_req_entry_i = '0;
        ch_req_data_i = '0;
        bank_req_ready_i = 1'b1;
        bank_resp_valid_i = 1'b0;
        bank_resp_ch_i = '0;
        bank_resp_data_i = '0;
        ch_resp_ready_i = 3'b111;
        step();
        step();
        neg();
        chk("rst_req_valid", 128'(bank_req_valid_o), 128'(0));
        chk("rst_grant", 128'(ch_req_grant_o), 128'(0));
        chk("rst_resp_valid", 128'(ch_resp_valid_o), 128'(0));
        chk("rst_resp_ready", 128'(bank_resp_ready_o), 128'(1));
        chk("rst_req_fields", 128'({bank_req_ch_o, bank_req_entry_o, bank_req_data_o}), 128'(0));
        chk("rst_inflight", 128'(dut.inflight_q), 128'(0));
        step();
        rstn_i = 1'b1;
        // single request from ch1
        ch_req_valid_i = 3'b010;
        ch_req_entry_i[1] = 3'd3;
        ch_req_data_i[1] = 64'hA5;
        push_req(2'd1);
        neg();
        chk("t1_grant", 128'(ch_req_grant_o), 128'(3'b010));
        step();
        ch_req_valid_i = '0;
        chk("t1_inflight", 128'(dut.inflight_q), 128'(1));
        neg();
        chk("t1_bank_valid", 128'(bank_req_valid_o), 128'(1));
        step();
        send_resp(2'd1, 64'h1111);
        step();
        bank_resp_valid_i = 1'b0;
        neg();
        chk("t1_resp_valid", 128'(ch_resp_valid_o), 128'(3'b010));
        step();
        chk("t1_inflight_ret", 128'(dut.inflight_q), 128'(0));
        // round robin from a fresh reset
        #2;
        rstn_i = 1'b0;
        step();
        rstn_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ch_req_entry_i[i] = 3'(i);
            ch_req_data_i[i] = 64'hD0 + 64'(i);
        end
        ch_req_valid_i = 3'b111;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] w;
            w = 2'(k % 3);
            push_req(w);
            step();
            ch_req_entry_i[w] = 3'(k + 3);
            ch_req_data_i[w] = 64'hD0 + 64'(k + 3);
        end
        ch_req_valid_i = '0;
        chk("rr_inflight", 128'(dut.inflight_q), 128'(4));
        // credit exhaustion
        ch_req_valid_i = 3'b010;
        ch_req_entry_i[1] = 3'd5;
        ch_req_data_i[1] = 64'hBEEF;
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("cr_no_grant", 128'(ch_req_grant_o), 128'(0));
            step();
        end
        send_resp(2'd0, 64'h5A5A);
        neg();
        chk("cr_no_grant_resp", 128'(ch_req_grant_o), 128'(0));
        step();
        bank_resp_valid_i = 1'b0;
        neg();
        chk("cr_grant_blocked", 128'(ch_req_grant_o), 128'(0));
        step();
        push_req(2'd1);
        neg();
        chk("cr_regrant", 128'(ch_req_grant_o), 128'(3'b010));
        step();
        ch_req_valid_i = '0;
        chk("cr_inflight", 128'(dut.inflight_q), 128'(4));
        send_resp(2'd1, 64'h1001);
        step();
        send_resp(2'd2, 64'h2002);
        step();
        send_resp(2'd0, 64'h3003);
        step();
        send_resp(2'd1, 64'h4004);
        step();
        bank_resp_valid_i = 1'b0;
        step();
        step();
        chk("cr_drained", 128'(dut.inflight_q), 128'(0));
        // bank stall with ch2 waiting behind a held request
        bank_req_ready_i = 1'b0;
        ch_req_valid_i = 3'b001;
        ch_req_entry_i[0] = 3'd1;
        ch_req_data_i[0] = 64'hA0;
        push_req(2'd0);
        neg();
        chk("st_first_grant", 128'(ch_req_grant_o), 128'(3'b001));
        step();
        ch_req_valid_i = 3'b100;
        ch_req_entry_i[2] = 3'd6;
        ch_req_data_i[2] = 64'hC2C2;
        for (int i = 0; i < 5; i++) begin
            neg();
            chk("st_no_grant", 128'(ch_req_grant_o), 128'(0));
            chk("st_hold", 128'({bank_req_valid_o, bank_req_ch_o, bank_req_entry_o, bank_req_data_o}),
                128'({1'b1, 2'd0, 3'd1, 64'hA0}));
            step();
        end
        bank_req_ready_i = 1'b1;
        push_req(2'd2);
        neg();
        chk("st_fire_grant", 128'(ch_req_grant_o), 128'(3'b100));
        step();
        ch_req_valid_i = '0;
        step();
        chk("st_inflight", 128'(dut.inflight_q), 128'(2));
        send_resp(2'd0, 64'hAAA0);
        step();
        send_resp(2'd2, 64'hAAA2);
        step();
        bank_resp_valid_i = 1'b0;
        step();
        step();
        chk("st_drained", 128'(dut.inflight_q), 128'(0));
        // response back-pressure on ch2
        ch_req_valid_i = 3'b100;
        ch_req_entry_i[2] = 3'd2;
        ch_req_data_i[2] = 64'h2222;
        push_req(2'd2);
        step();
        ch_req_valid_i = 3'b001;
        ch_req_entry_i[0] = 3'd4;
        ch_req_data_i[0] = 64'h4444;
        push_req(2'd0);
        step();
        ch_req_valid_i = '0;
        step();
        chk("bp_inflight", 128'(dut.inflight_q), 128'(2));
        ch_resp_ready_i = 3'b011;
        send_resp(2'd2, 64'h22);
        step();
        send_resp(2'd0, 64'h33);
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("bp_valid_held", 128'(ch_resp_valid_o), 128'(3'b100));
            chk("bp_resp_ready", 128'(bank_resp_ready_o), 128'(0));
            step();
        end
        ch_resp_ready_i = 3'b111;
        neg();
        chk("bp_ready_release", 128'(bank_resp_ready_o), 128'(1));
        step();
        bank_resp_valid_i = 1'b0;
        chk("bp_inflight_dec", 128'(dut.inflight_q), 128'(1));
        neg();
        chk("bp_second_valid", 128'(ch_resp_valid_o), 128'(3'b001));
        step();
        chk("bp_drained", 128'(dut.inflight_q), 128'(0));
        // grant and response handshake in the same cycle
        ch_req_valid_i = 3'b010;
        ch_req_entry_i[1] = 3'd7;
        ch_req_data_i[1] = 64'h7777;
        push_req(2'd1);
        step();
        ch_req_valid_i = '0;
        step();
        send_resp(2'd1, 64'h77);
        step();
        bank_resp_valid_i = 1'b0;
        ch_req_valid_i = 3'b001;
        ch_req_entry_i[0] = 3'd1;
        ch_req_data_i[0] = 64'h0101;
        push_req(2'd0);
        neg();
        chk("sim_grant", 128'(ch_req_grant_o), 128'(3'b001));
        chk("sim_resp", 128'(ch_resp_valid_o), 128'(3'b010));
        step();
        ch_req_valid_i = '0;
        chk("sim_inflight", 128'(dut.inflight_q), 128'(1));
        // asynchronous reset in the middle of a burst
        ch_req_valid_i = 3'b001;
        ch_req_entry_i[0] = 3'd2;
        ch_req_data_i[0] = 64'hB0;
        push_req(2'd0);
        step();
        ch_req_entry_i[0] = 3'd3;
        ch_req_data_i[0] = 64'hB1;
        push_req(2'd0);
        step();
        #2;
        rstn_i = 1'b0;
        #1;
        chk("ar_req_valid", 128'(bank_req_valid_o), 128'(0));
        chk("ar_grant", 128'(ch_req_grant_o), 128'(0));
        chk("ar_resp_valid", 128'(ch_resp_valid_o), 128'(0));
        chk("ar_resp_ready", 128'(bank_resp_ready_o), 128'(1));
        chk("ar_inflight", 128'(dut.inflight_q), 128'(0));
        exp_gnt.delete();
        exp_req.delete();
        exp_resp.delete();
        ch_req_valid_i = '0;
        step();
        step();
        rstn_i = 1'b1;
        // channel 0 leads again after reset
        ch_req_valid_i = 3'b101;
        ch_req_entry_i[0] = 3'd5;
        ch_req_data_i[0] = 64'hF0;
        ch_req_entry_i[2] = 3'd6;
        ch_req_data_i[2] = 64'hF2;
        push_req(2'd0);
        neg();
        chk("post_rst_grant0", 128'(ch_req_grant_o), 128'(3'b001));
        step();
        ch_req_valid_i = 3'b100;
        push_req(2'd2);
        neg();
        chk("post_rst_grant2", 128'(ch_req_grant_o), 128'(3'b100));
        step();
        ch_req_valid_i = '0;
        step();
        step();
        chk("end_gnt_queue", 128'(exp_gnt.size()), 128'(0));
        chk("end_req_queue", 128'(exp_req.size()), 128'(0));
        chk("end_resp_queue", 128'(exp_resp.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
